// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared constants, request type and helpers for the writeback port arbiter
package wb_port_arbiter_pkg;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_XZR_SP = 5'd31;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
    logic                 sp;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_M    = 2'd2
  } wb_gnt_e;

  // Index 31 is the zero register unless the source flags it as an SP write.
  function automatic logic is_xzr(input logic [REG_IDX_W-1:0] rd, input logic sp);
    return (rd == REG_XZR_SP) && !sp;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - writeback request/ready and register-file write port bundle
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic                 a_valid;
  logic [REG_IDX_W-1:0] a_rd;
  logic [XLEN-1:0]      a_data;
  logic                 a_sp;
  logic                 a_ready;

  logic                 m_valid;
  logic [REG_IDX_W-1:0] m_rd;
  logic [XLEN-1:0]      m_data;
  logic                 m_sp;
  logic                 m_ready;

  logic                 RegWrite;
  logic [REG_IDX_W-1:0] Write_register;
  logic [XLEN-1:0]      Write_d;

  modport slave (
    input  a_valid, a_rd, a_data, a_sp,
    input  m_valid, m_rd, m_data, m_sp,
    output a_ready, m_ready,
    output RegWrite, Write_register, Write_d
  );

  modport master (
    output a_valid, a_rd, a_data, a_sp,
    output m_valid, m_rd, m_data, m_sp,
    input  a_ready, m_ready,
    input  RegWrite, Write_register, Write_d
  );

endinterface

// File: rtl/wb_starve_ctr.sv
// rtl/wb_starve_ctr.sv - saturating count of consecutive cycles the load source lost arbitration
module wb_starve_ctr #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Clear has priority so a granted load always restarts the window.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q >= LIMIT);

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - arbitrates ALU and load writebacks onto one registered register-file write port
// Optional conflict/drop counters are compiled in with WB_ARB_PERF_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  wb_port_arbiter_if.slave  wb
`ifdef WB_ARB_PERF_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  wb_req_t a_req;
  wb_req_t m_req;
  wb_req_t sel_req;
  wb_gnt_e gnt;
  logic    both;
  logic    starved;
  logic    xfer;
  logic    drop;

  always_comb begin
    a_req = '{valid: wb.a_valid, rd: wb.a_rd, data: wb.a_data, sp: wb.a_sp};
    m_req = '{valid: wb.m_valid, rd: wb.m_rd, data: wb.m_data, sp: wb.m_sp};
    both  = a_req.valid && m_req.valid;

    gnt = GNT_NONE;
    if (reset) begin
      gnt = GNT_NONE;
    end else if (both) begin
      gnt = starved ? GNT_M : GNT_A;
    end else if (a_req.valid) begin
      gnt = GNT_A;
    end else if (m_req.valid) begin
      gnt = GNT_M;
    end

    sel_req = (gnt == GNT_M) ? m_req : a_req;
    xfer    = (gnt != GNT_NONE) && sel_req.valid;
    drop    = xfer && is_xzr(sel_req.rd, sel_req.sp);
  end

  assign wb.a_ready = (gnt == GNT_A);
  assign wb.m_ready = (gnt == GNT_M);

  wb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .clk      (clk),
    .rst      (reset),
    .inc      (both && (gnt == GNT_A)),
    .clr      ((gnt == GNT_M) || !wb.m_valid),
    .at_limit (starved)
  );

  logic                 reg_write_d, reg_write_q;
  logic [REG_IDX_W-1:0] wr_idx_d,    wr_idx_q;
  logic [XLEN-1:0]      wr_data_d,   wr_data_q;

  // Index and data hold across idle and dropped cycles; only the enable pulses.
  always_comb begin
    reg_write_d = xfer && !drop;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    if (reg_write_d) begin
      wr_idx_d  = sel_req.rd;
      wr_data_d = sel_req.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign wb.RegWrite       = reg_write_q;
  assign wb.Write_register = wr_idx_q;
  assign wb.Write_d        = wr_data_q;

`ifdef WB_ARB_PERF_EN
  logic [15:0] conflict_cnt_d, conflict_cnt_q;
  logic [15:0] drop_cnt_d,     drop_cnt_q;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    if (both && !reset && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign drop_cnt     = drop_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for the writeback port arbiter
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int STARVE_LIMIT = 3;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  logic clk;
  logic reset;
  int   tests_run = 0;
  int   failed    = 0;

  wr_t         sb_q[$];
  wr_t         mon_e;
  logic [4:0]  mdl_reg  = '0;
  logic [63:0] mdl_data = '0;
  int          m_starve = 0;
  int          m_conf   = 0;
  int          m_drop   = 0;
  logic [63:0] rf [32];

  wb_port_arbiter_if bus ();

`ifdef WB_ARB_PERF_EN
  logic [15:0] conflict_cnt;
  logic [15:0] drop_cnt;
`endif

  wb_port_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
`ifdef WB_ARB_PERF_EN
    ,
    .conflict_cnt (conflict_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Register file fed only by the DUT write port.
  always @(posedge clk) begin
    if (!reset && bus.RegWrite) rf[bus.Write_register] <= bus.Write_d;
  end

  // Output monitor: one scoreboard entry per cycle, empty queue means no write.
  always begin
    @(posedge clk);
    #3;
    if (!reset) begin
      if (sb_q.size() > 0) mon_e = sb_q.pop_front();
      else mon_e = '{we: 1'b0, rd: 5'd0, data: 64'd0};
      if (mon_e.we) begin
        mdl_reg  = mon_e.rd;
        mdl_data = mon_e.data;
      end
      tests_run++;
      if (bus.RegWrite !== mon_e.we || bus.Write_register !== mdl_reg || bus.Write_d !== mdl_data) begin
        failed++;
        $display("FAIL wb_write t=%0t: RegWrite=%0b reg=%0d data=%h, expected RegWrite=%0b reg=%0d data=%h",
                 $time, bus.RegWrite, bus.Write_register, bus.Write_d, mon_e.we, mdl_reg, mdl_data);
      end
    end
  end

  task automatic apply(input logic av, input logic [4:0] ard, input logic [63:0] ad, input logic asp,
                       input logic mv, input logic [4:0] mrd, input logic [63:0] md, input logic msp,
                       output logic ga, output logic gm);
    wr_t e;
    @(posedge clk);
    #1;
    bus.a_valid = av; bus.a_rd = ard; bus.a_data = ad; bus.a_sp = asp;
    bus.m_valid = mv; bus.m_rd = mrd; bus.m_data = md; bus.m_sp = msp;
    ga = av && !(mv && (m_starve >= STARVE_LIMIT));
    gm = mv && !ga;
    @(negedge clk);
    if (ga)      e = '{we: !(ard == 5'd31 && !asp), rd: ard, data: ad};
    else if (gm) e = '{we: !(mrd == 5'd31 && !msp), rd: mrd, data: md};
    else         e = '{we: 1'b0, rd: 5'd0, data: 64'd0};
    sb_q.push_back(e);
    if (av && mv) m_conf++;
    if ((ga || gm) && !e.we) m_drop++;
    if (av && mv && ga) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
    else if (gm || !mv) m_starve = 0;
  endtask

  task automatic idle();
    logic ga, gm;
    apply(0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
  endtask

  task automatic test_reset();
    logic ga, gm;
    reset = 1'b1;
    bus.a_valid = 1; bus.a_rd = 5'd9; bus.a_data = 64'h99; bus.a_sp = 0;
    bus.m_valid = 1; bus.m_rd = 5'd4; bus.m_data = 64'h44; bus.m_sp = 0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.RegWrite !== 1'b0 || bus.Write_register !== 5'd0 || bus.Write_d !== 64'd0 ||
        bus.a_ready !== 1'b0 || bus.m_ready !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: RegWrite=%0b reg=%0d data=%h a_ready=%0b m_ready=%0b, expected all 0",
               bus.RegWrite, bus.Write_register, bus.Write_d, bus.a_ready, bus.m_ready);
    end
    bus.a_valid = 0; bus.m_valid = 0;
    reset = 1'b0;

    apply(1, 5'd9, 64'h99, 0, 0, 0, 0, 0, ga, gm);
    tests_run++;
    if (bus.a_ready !== 1'b1) begin
      failed++; $display("FAIL reset_pre_xfer: a_ready=%0b, expected 1", bus.a_ready);
    end
    @(posedge clk);
    #4;
    tests_run++;
    if (bus.RegWrite !== 1'b1 || bus.Write_register !== 5'd9) begin
      failed++; $display("FAIL reset_inflight: RegWrite=%0b reg=%0d, expected 1 9", bus.RegWrite, bus.Write_register);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.RegWrite !== 1'b0 || bus.a_ready !== 1'b0 || bus.m_ready !== 1'b0) begin
      failed++;
      $display("FAIL reset_async: RegWrite=%0b a_ready=%0b m_ready=%0b, expected 0 0 0", bus.RegWrite, bus.a_ready, bus.m_ready);
    end
    sb_q.delete();
    mdl_reg = '0; mdl_data = '0; m_starve = 0; m_conf = 0; m_drop = 0;
    bus.a_rd = 5'd5; bus.a_data = 64'h1234;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.a_ready !== 1'b1 || bus.m_ready !== 1'b0) begin
      failed++; $display("FAIL reset_rearb: a_ready=%0b m_ready=%0b, expected 1 0", bus.a_ready, bus.m_ready);
    end
    sb_q.push_back('{we: 1'b1, rd: 5'd5, data: 64'h1234});
    idle();
    tests_run++;
    if (bus.RegWrite !== 1'b1 || bus.Write_register !== 5'd5 || bus.Write_d !== 64'h1234) begin
      failed++;
      $display("FAIL reset_after: RegWrite=%0b reg=%0d data=%h, expected 1 5 1234", bus.RegWrite, bus.Write_register, bus.Write_d);
    end
    idle();
  endtask

  task automatic test_m_only();
    logic ga, gm;
    apply(0, 0, 0, 0, 1, 5'd7, 64'hDEADBEEF, 0, ga, gm);
    tests_run++;
    if (bus.m_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
      failed++; $display("FAIL m_only_ready: a_ready=%0b m_ready=%0b, expected 0 1", bus.a_ready, bus.m_ready);
    end
    idle();
    tests_run++;
    if (bus.RegWrite !== 1'b1 || bus.Write_register !== 5'd7 || bus.Write_d !== 64'hDEADBEEF) begin
      failed++;
      $display("FAIL m_only_write: RegWrite=%0b reg=%0d data=%h, expected 1 7 deadbeef", bus.RegWrite, bus.Write_register, bus.Write_d);
    end
    idle();
  endtask

  task automatic test_starvation();
    logic ga, gm, exp_m;
    int a_i = 0;
    int m_i = 0;
    for (int i = 0; i < 8; i++) begin
      apply(1, 5'(10 + a_i), 64'(100 + a_i), 0, 1, 5'(20 + m_i), 64'(200 + m_i), 0, ga, gm);
      exp_m = ((i % 4) == 3);
      tests_run++;
      if (bus.a_ready !== ~exp_m || bus.m_ready !== exp_m) begin
        failed++;
        $display("FAIL starve_grant[%0d]: a_ready=%0b m_ready=%0b, expected %0b %0b", i, bus.a_ready, bus.m_ready, ~exp_m, exp_m);
      end
      tests_run++;
      if (dut.u_starve.cnt_q !== 4'(i % 4)) begin
        failed++; $display("FAIL starve_cnt[%0d]: cnt=%0d, expected %0d", i, dut.u_starve.cnt_q, i % 4);
      end
      if (bus.a_ready) a_i++;
      if (bus.m_ready) m_i++;
    end
    idle();
    idle();
  endtask

  task automatic test_xzr();
    logic ga, gm;
    apply(1, 5'd31, 64'h77, 0, 0, 0, 0, 0, ga, gm);
    tests_run++;
    if (bus.a_ready !== 1'b1) begin
      failed++; $display("FAIL xzr_ready: a_ready=%0b, expected 1", bus.a_ready);
    end
    apply(1, 5'd31, 64'h8000, 1, 0, 0, 0, 0, ga, gm);
    tests_run++;
    if (bus.RegWrite !== 1'b0) begin
      failed++; $display("FAIL xzr_drop: RegWrite=%0b, expected 0", bus.RegWrite);
    end
    apply(0, 0, 0, 0, 1, 5'd31, 64'h66, 0, ga, gm);
    tests_run++;
    if (bus.m_ready !== 1'b1 || bus.RegWrite !== 1'b1 || bus.Write_register !== 5'd31 || bus.Write_d !== 64'h8000) begin
      failed++;
      $display("FAIL xzr_sp: m_ready=%0b RegWrite=%0b reg=%0d data=%h, expected 1 1 31 8000",
               bus.m_ready, bus.RegWrite, bus.Write_register, bus.Write_d);
    end
    idle();
    idle();
  endtask

  task automatic test_same_rd();
    logic ga, gm;
    apply(1, 5'd3, 64'd1, 0, 1, 5'd3, 64'd2, 0, ga, gm);
    tests_run++;
    if (bus.a_ready !== 1'b1 || bus.m_ready !== 1'b0) begin
      failed++; $display("FAIL same_rd_first: a_ready=%0b m_ready=%0b, expected 1 0", bus.a_ready, bus.m_ready);
    end
    apply(0, 0, 0, 0, 1, 5'd3, 64'd2, 0, ga, gm);
    tests_run++;
    if (bus.m_ready !== 1'b1) begin
      failed++; $display("FAIL same_rd_second: m_ready=%0b, expected 1", bus.m_ready);
    end
    idle();
    tests_run++;
    if (rf[3] !== 64'd1 || bus.Write_d !== 64'd2) begin
      failed++; $display("FAIL same_rd_order: rf3=%0d Write_d=%0d, expected 1 2", rf[3], bus.Write_d);
    end
    idle();
    tests_run++;
    if (rf[3] !== 64'd2) begin
      failed++; $display("FAIL same_rd_final: rf3=%0d, expected 2", rf[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic ga, gm;
    logic av = 0, mv = 0, asp = 0, msp = 0;
    logic [4:0] ard = 0, mrd = 0;
    logic [63:0] ad = 0, md = 0;
    for (int i = 0; i < 24; i++) begin
      if (!av && $urandom_range(0, 3) != 0) begin
        av = 1; ard = 5'($urandom_range(0, 31)); ad = {$urandom, $urandom}; asp = 1'($urandom_range(0, 1));
      end
      if (!mv && $urandom_range(0, 3) != 0) begin
        mv = 1; mrd = 5'($urandom_range(0, 31)); md = {$urandom, $urandom}; msp = 1'($urandom_range(0, 1));
      end
      apply(av, ard, ad, asp, mv, mrd, md, msp, ga, gm);
      tests_run++;
      if (bus.a_ready !== ga || bus.m_ready !== gm) begin
        failed++;
        $display("FAIL b2b_grant[%0d]: a_ready=%0b m_ready=%0b, expected %0b %0b", i, bus.a_ready, bus.m_ready, ga, gm);
      end
      if (bus.a_ready) av = 0;
      if (bus.m_ready) mv = 0;
    end
    idle();
    idle();
  endtask

`ifdef WB_ARB_PERF_EN
  task automatic test_perf();
    tests_run++;
    if (conflict_cnt !== 16'(m_conf) || drop_cnt !== 16'(m_drop)) begin
      failed++;
      $display("FAIL perf_counts: conflict=%0d drop=%0d, expected %0d %0d", conflict_cnt, drop_cnt, m_conf, m_drop);
    end
  endtask
`endif

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    reset = 1'b1;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0; bus.a_sp = 0;
    bus.m_valid = 0; bus.m_rd = 0; bus.m_data = 0; bus.m_sp = 0;
    test_reset();
    test_m_only();
    test_starvation();
    test_xzr();
    test_same_rd();
    test_back_to_back();
`ifdef WB_ARB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
